// File: rtl/pdp8_image_loader_if.sv
// pdp8_image_loader_if
// Purpose : groups the two streams handled by the PAL image loader: the
//           incoming byte stream and the outgoing memory write port.
// Signals : byte_valid/byte_data/byte_ready/eof  - image byte stream
//           mem_write_enable/mem_address/mem_write_data/mem_finished
//                                                - memory write handshake
// Modports: master - the loader (consumes bytes, issues writes)
//           slave  - the environment (byte source and memory)
interface pdp8_image_loader_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 12
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              eof;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_write_data;
  logic              mem_finished;

  modport master (
    input  byte_valid, byte_data, eof, mem_finished,
    output byte_ready, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    output byte_valid, byte_data, eof, mem_finished,
    input  byte_ready, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/pdp8_image_loader.sv
// pdp8_image_loader
// Purpose : reads a PDP-8 PAL binary-format image from a byte stream and
//           writes it into memory. Bytes with bit 7 set are leader/trailer.
//           Non-leader bytes pair up into words; a pair whose first byte has
//           bit 6 set is an origin, otherwise it is a data word written at
//           the current address. On end of stream the PC is loaded with
//           START_PC and the CPU is allowed to run; an unpaired byte at end
//           of stream flags err instead.
// Ports   : clk, btnCpuReset (async, active low), start (load pulse)
//           bus            - byte stream + memory write port (master side)
//           load_pc/pc_value - one-cycle PC load strobe and value
//           busy, run, err - load status
//           words_written  - saturating count of completed data writes
module pdp8_image_loader #(
  parameter int              WORD_W   = 12,
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] START_PC = ADDR_W'(12'o200)
) (
  input  logic                  clk,
  input  logic                  btnCpuReset,
  input  logic                  start,
  pdp8_image_loader_if.master   bus,
  output logic                  load_pc,
  output logic [ADDR_W-1:0]     pc_value,
  output logic                  busy,
  output logic                  run,
  output logic                  err,
  output logic [ADDR_W:0]       words_written
);

  localparam int H     = WORD_W / 2;
  localparam int EXT_W = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_SETPC = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q;
  logic              hi_org_q;      // bit 6 of the stored high byte
  logic [H-1:0]      hi_fld_q;      // high half of the word being assembled
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              we_q;
  logic              ready_q;
  logic              busy_q;
  logic              run_q;
  logic              err_q;
  logic              load_pc_q;
  logic [ADDR_W:0]   cnt_q;

  logic [WORD_W-1:0] word_s;
  logic [EXT_W-1:0]  word_ext_s;
  logic              take_s;
  logic              leader_s;

  assign word_s     = {hi_fld_q, bus.byte_data[H-1:0]};
  assign word_ext_s = EXT_W'(word_s);   // zero-extends when ADDR_W > WORD_W
  assign take_s     = bus.byte_valid && ready_q;
  assign leader_s   = bus.byte_data[7];

  assign bus.byte_ready       = ready_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = data_q;
  assign load_pc              = load_pc_q;
  assign pc_value             = START_PC;
  assign busy                 = busy_q;
  assign run                  = run_q;
  assign err                  = err_q;
  assign words_written        = cnt_q;

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q   <= S_IDLE;
      hi_org_q  <= 1'b0;
      hi_fld_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      load_pc_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      load_pc_q <= 1'b0;  // strobe is high only for the single SETPC cycle
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;   // each load starts at address 0 unless an origin follows
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_HI;
          end
        end
        S_HI: begin
          if (take_s) begin
            if (!leader_s) begin
              hi_org_q <= bus.byte_data[6];
              hi_fld_q <= bus.byte_data[H-1:0];
              state_q  <= S_LO;
            end
          end else if (bus.eof) begin
            ready_q   <= 1'b0;
            load_pc_q <= 1'b1;
            state_q   <= S_SETPC;
          end
        end
        S_LO: begin
          if (take_s) begin
            if (!leader_s) begin
              if (hi_org_q) begin
                addr_q  <= word_ext_s[ADDR_W-1:0];
                state_q <= S_HI;
              end else begin
                data_q  <= word_s;
                we_q    <= 1'b1;
                ready_q <= 1'b0;
                state_q <= S_WRITE;
              end
            end
          end else if (bus.eof) begin
            // unpaired trailing byte: abort without starting the CPU
            err_q   <= 1'b1;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_WRITE: begin
          if (bus.mem_finished) begin
            we_q    <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(1);
            cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + (ADDR_W+1)'(1);
            ready_q <= 1'b1;
            state_q <= S_HI;
          end
        end
        S_SETPC: begin
          run_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: begin
          we_q    <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
